// File: rtl/spi_regs_pkg.sv
// rtl/spi_regs_pkg.sv - shared register map, CTRL bit positions and reset values
package spi_regs;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_PERIOD   = 2'd2;
    localparam logic [1:0] ADDR_DUTY     = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_INV     = 1;
    localparam int CTRL_ONESHOT = 2;

    localparam logic [7:0] RST_CTRL     = 8'h00;
    localparam logic [7:0] RST_PRESCALE = 8'h00;
    localparam logic [7:0] RST_PERIOD   = 8'hFF;
    localparam logic [7:0] RST_DUTY     = 8'h80;

    typedef struct packed {
        logic oneshot;
        logic inv;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/pwm_counter.sv
// rtl/pwm_counter.sv - prescaler plus period counter producing cnt and the wrap strobe
module pwm_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] presc_sh,
    input  logic [7:0] period_sh,
    output logic [7:0] cnt,
    output logic       wrap
);

    logic [7:0] presc_cnt;
    logic       tick;

    assign tick = en && (presc_cnt == presc_sh);
    assign wrap = tick && (cnt == period_sh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= 8'd0;
            cnt       <= 8'd0;
        end else if (!en) begin
            presc_cnt <= 8'd0;
            cnt       <= 8'd0;
        end else begin
            presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
            if (tick) begin
                cnt <= wrap ? 8'd0 : cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/spi_pwm_gen.sv
// rtl/spi_pwm_gen.sv - register file, period-aligned shadows and PWM output stage
module spi_pwm_gen
    import spi_regs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [1:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       pwm_out,
    output logic       period_tick,
    output logic       busy
);

    ctrl_t      ctrl;
    logic [7:0] prescale;
    logic [7:0] period;
    logic [7:0] duty;
    logic [7:0] presc_sh;
    logic [7:0] period_sh;
    logic [7:0] duty_sh;
    logic [7:0] cnt;
    logic       wrap;
    logic       raw;

    // A CTRL write is applied after the oneshot clear so the write wins on a shared edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= ctrl_t'(RST_CTRL[2:0]);
            prescale <= RST_PRESCALE;
            period   <= RST_PERIOD;
            duty     <= RST_DUTY;
        end else begin
            if (wrap && ctrl.oneshot) begin
                ctrl.en <= 1'b0;
            end
            if (wr_en) begin
                case (wr_addr)
                    ADDR_CTRL: ctrl <= '{oneshot: wr_data[CTRL_ONESHOT],
                                         inv:     wr_data[CTRL_INV],
                                         en:      wr_data[CTRL_EN]};
                    ADDR_PRESCALE: prescale <= wr_data;
                    ADDR_PERIOD:   period   <= wr_data;
                    ADDR_DUTY:     duty     <= wr_data;
                    default: ;
                endcase
            end
        end
    end

    // Shadows track the live registers while idle and only resample at a period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_sh  <= RST_PRESCALE;
            period_sh <= RST_PERIOD;
            duty_sh   <= RST_DUTY;
        end else if (!ctrl.en || wrap) begin
            presc_sh  <= prescale;
            period_sh <= period;
            duty_sh   <= duty;
        end
    end

    pwm_counter u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (ctrl.en),
        .presc_sh  (presc_sh),
        .period_sh (period_sh),
        .cnt       (cnt),
        .wrap      (wrap)
    );

    assign raw  = ctrl.en && (cnt < duty_sh);
    assign busy = ctrl.en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            pwm_out     <= raw ^ ctrl.inv;
            period_tick <= wrap;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_CTRL:     rd_data = {5'b00000, ctrl};
            ADDR_PRESCALE: rd_data = prescale;
            ADDR_PERIOD:   rd_data = period;
            ADDR_DUTY:     rd_data = duty;
            default:       rd_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_spi_pwm_gen.sv
// tb/tb_spi_pwm_gen.sv - scoreboard bench for spi_pwm_gen against a period-position model
module tb_spi_pwm_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic [1:0] rd_addr = 2'd0;
    logic [7:0] rd_data;
    logic       pwm_out;
    logic       period_tick;
    logic       busy;

    spi_pwm_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pwm;
        logic       tick;
        logic       busy;
        logic [7:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: position within the current period rather than separate counters.
    bit m_en, m_inv, m_os;
    int m_pre, m_per, m_duty;
    int s_pre, s_per, s_duty;
    int pos;
    bit m_pwm, m_tick;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] reg_val(input int a);
        case (a)
            0:       return {5'b0, m_os, m_inv, m_en};
            1:       return 8'(m_pre);
            2:       return 8'(m_per);
            default: return 8'(m_duty);
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_inv = 0; m_os = 0;
        m_pre = 0; m_per = 255; m_duty = 128;
        s_pre = 0; s_per = 255; s_duty = 128;
        pos = 0; m_pwm = 0; m_tick = 0;
    endtask

    task automatic model_edge(input bit we, input int addr, input logic [7:0] d);
        int  len;
        bit  wrap;
        bit  raw;
        if (m_en) begin
            len  = (s_per + 1) * (s_pre + 1);
            wrap = (pos == len - 1);
            raw  = ((pos / (s_pre + 1)) < s_duty);
        end else begin
            wrap = 0;
            raw  = 0;
        end
        m_pwm  = raw ^ m_inv;
        m_tick = wrap;
        if (!m_en || wrap) begin
            s_pre = m_pre; s_per = m_per; s_duty = m_duty;
        end
        pos = (m_en && !wrap) ? pos + 1 : 0;
        if (wrap && m_os) m_en = 0;
        if (we) begin
            case (addr)
                0: begin m_en = d[0]; m_inv = d[1]; m_os = d[2]; end
                1: m_pre = d;
                2: m_per = d;
                default: m_duty = d;
            endcase
        end
    endtask

    task automatic step(input bit rst, input bit we, input int addr, input int data, input int raddr);
        @(negedge clk);
        wr_en   = we;
        wr_addr = 2'(addr);
        wr_data = 8'(data);
        rd_addr = 2'(raddr);
        if (!rst) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check("async_rst_pwm", {7'b0, pwm_out}, 8'h00);
            check("async_rst_tick", {7'b0, period_tick}, 8'h00);
        end else begin
            rst_n = 1'b1;
            model_edge(we, addr, 8'(data));
        end
        exp_q.push_back('{pwm: m_pwm, tick: m_tick, busy: m_en, rd: reg_val(raddr)});
    endtask

    task automatic wr(input int addr, input int data);
        step(1, 1, addr, data, addr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, $urandom_range(0, 3));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pwm_out", {7'b0, pwm_out}, {7'b0, e.pwm});
                check("period_tick", {7'b0, period_tick}, {7'b0, e.tick});
                check("busy", {7'b0, busy}, {7'b0, e.busy});
                check("rd_data", rd_data, e.rd);
            end
        end
    end

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, i);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, i);

        wr(2, 3); wr(1, 0); wr(3, 2); wr(0, 1);
        idle(13);

        wr(0, 0); wr(2, 4); wr(1, 1); wr(3, 0); wr(0, 1);
        idle(4); wr(3, 9); idle(26);

        wr(0, 0); wr(2, 1); wr(1, 0); wr(3, 1); wr(0, 8'h07);
        idle(8);

        wr(0, 0); wr(2, 255); wr(3, 128); wr(0, 1);
        idle(50); wr(2, 2); idle(215);

        step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 2);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            int a;
            int d;
            if ($urandom_range(0, 299) == 0) begin
                step(0, 0, 0, 0, $urandom_range(0, 3));
            end else if ($urandom_range(0, 7) == 0) begin
                a = $urandom_range(0, 3);
                case (a)
                    0:       d = $urandom_range(0, 255);
                    3:       d = $urandom_range(0, 9);
                    default: d = $urandom_range(0, 7);
                endcase
                step(1, 1, a, d, $urandom_range(0, 3));
            end else begin
                idle(1);
            end
        end
        idle(2);

        repeat (4) @(posedge clk);
        #2;
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
